// File: rtl/iosys_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : iosys_mem_arbiter
//  Description : Two-requester arbiter (firmware loader / CPU) onto a single
//                32-bit memory port, with round-robin tie breaking and
//                write protection of the firmware region under fw_lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module iosys_mem_arbiter #(
  parameter logic [22:0] PROT_TOP = 23'h04_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [22:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic        cpu_valid,
  input  logic [22:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic        fw_lock,
  output logic        prot_viol,
  output logic        rv_valid,
  input  logic        rv_ready,
  output logic [22:0] rv_addr,
  output logic [31:0] rv_wdata,
  output logic [3:0]  rv_wstrb,
  input  logic [31:0] rv_rdata,
  output logic        busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] GRANT_LD  = 3'd1;
  localparam logic [2:0] GRANT_CPU = 3'd2;
  localparam logic [2:0] BLOCK     = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0] state;
  // 1 = CPU received the most recent grant, so the loader wins the next tie
  logic       last_grant_cpu;
  logic       cpu_blocked;
  logic       pick_ld;

  // A CPU write into the locked firmware region never reaches memory
  assign cpu_blocked = (cpu_wstrb != 4'b0000) && fw_lock && (cpu_addr < PROT_TOP);
  // Loader is chosen when alone, or on a tie when the CPU was granted last
  assign pick_ld     = ld_valid && (!cpu_valid || last_grant_cpu);
  assign busy        = (state != IDLE);

  // Arbitration FSM; memory request and ready pulses are all registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last_grant_cpu <= 1'b1;
      rv_valid       <= 1'b0;
      rv_addr        <= 23'd0;
      rv_wdata       <= 32'd0;
      rv_wstrb       <= 4'd0;
      ld_ready       <= 1'b0;
      cpu_ready      <= 1'b0;
      cpu_rdata      <= 32'd0;
      prot_viol      <= 1'b0;
    end else begin
      ld_ready  <= 1'b0;
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_ld) begin
            state          <= GRANT_LD;
            last_grant_cpu <= 1'b0;
            rv_valid       <= 1'b1;
            rv_addr        <= ld_addr;
            rv_wdata       <= {4{ld_data}};
            rv_wstrb       <= 4'b0001 << ld_addr[1:0];
          end else if (cpu_valid) begin
            last_grant_cpu <= 1'b1;
            if (cpu_blocked) begin
              state     <= BLOCK;
              prot_viol <= 1'b1;
            end else begin
              state    <= GRANT_CPU;
              rv_valid <= 1'b1;
              rv_addr  <= {cpu_addr[22:2], 2'b00};
              rv_wdata <= cpu_wdata;
              rv_wstrb <= cpu_wstrb;
            end
          end
        end
        GRANT_LD: begin
          if (rv_ready) begin
            rv_valid <= 1'b0;
            ld_ready <= 1'b1;
            state    <= DONE;
          end
        end
        GRANT_CPU: begin
          if (rv_ready) begin
            rv_valid  <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_rdata <= rv_rdata;
            state     <= DONE;
          end
        end
        BLOCK: begin
          cpu_ready <= 1'b1;
          cpu_rdata <= 32'd0;
          state     <= DONE;
        end
        // DONE gives the requester one cycle to drop valid before re-arbitration
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          rv_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iosys_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iosys_mem_arbiter
//  Description : Directed, table-driven bench for iosys_mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iosys_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [22:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        cpu_valid;
  logic [22:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        fw_lock;
  logic        prot_viol;
  logic        rv_valid;
  logic        rv_ready;
  logic [22:0] rv_addr;
  logic [31:0] rv_wdata;
  logic [3:0]  rv_wstrb;
  logic [31:0] rv_rdata;
  logic        busy;

  int tests = 0;
  int fails = 0;

  iosys_mem_arbiter #(.PROT_TOP(23'h04_0000)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .fw_lock(fw_lock), .prot_viol(prot_viol),
    .rv_valid(rv_valid), .rv_ready(rv_ready), .rv_addr(rv_addr),
    .rv_wdata(rv_wdata), .rv_wstrb(rv_wstrb), .rv_rdata(rv_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_cpu;
    logic [22:0] addr;
    logic [31:0] wdata;     // loader uses [7:0]
    logic [3:0]  wstrb;
    logic        lock;
    logic [31:0] mem_rdata;
    int          dly;       // cycles from rv_valid to rv_ready
    logic        blocked;
    logic [22:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_rdata;
    logic        e_viol;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " rv_valid"},  {31'd0, rv_valid},  32'd0);
    check({tag, " rv_addr"},   {9'd0, rv_addr},    32'd0);
    check({tag, " rv_wdata"},  rv_wdata,           32'd0);
    check({tag, " rv_wstrb"},  {28'd0, rv_wstrb},  32'd0);
    check({tag, " ld_ready"},  {31'd0, ld_ready},  32'd0);
    check({tag, " cpu_ready"}, {31'd0, cpu_ready}, 32'd0);
    check({tag, " cpu_rdata"}, cpu_rdata,          32'd0);
    check({tag, " prot_viol"}, {31'd0, prot_viol}, 32'd0);
    check({tag, " busy"},      {31'd0, busy},      32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ld_valid = 1'b0; cpu_valid = 1'b0; rv_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait (bounded) until rv_valid or either ready is high; returns negedges waited
  task automatic wait_event(input string name, output int n);
    bit got;
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (rv_valid || ld_ready || cpu_ready) got = 1'b1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s timeout: got no event expected event within 20 cycles", name);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    string t;
    logic rdy;
    t = $sformatf("vec%0d", idx);
    fw_lock = v.lock;
    if (v.is_cpu) begin
      cpu_valid = 1'b1; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_wstrb = v.wstrb;
    end else begin
      ld_valid = 1'b1; ld_addr = v.addr; ld_data = v.wdata[7:0];
    end
    wait_event(t, n);
    if (v.blocked) begin
      check({t, " blk rv_valid"},  {31'd0, rv_valid},  32'd0);
      check({t, " blk cpu_ready"}, {31'd0, cpu_ready}, 32'd1);
      check({t, " blk cpu_rdata"}, cpu_rdata,          32'd0);
      check({t, " blk latency"},   n,                  32'd2);
    end else begin
      check({t, " rv_valid"}, {31'd0, rv_valid}, 32'd1);
      check({t, " issue lat"}, n, 32'd1);
      check({t, " rv_addr"},  {9'd0, rv_addr},   {9'd0, v.e_addr});
      check({t, " rv_wdata"}, rv_wdata,          v.e_wdata);
      check({t, " rv_wstrb"}, {28'd0, rv_wstrb}, {28'd0, v.e_wstrb});
      repeat (v.dly) @(negedge clk);
      check({t, " held rv_valid"}, {31'd0, rv_valid}, 32'd1);
      check({t, " held rv_addr"},  {9'd0, rv_addr},   {9'd0, v.e_addr});
      rv_ready = 1'b1; rv_rdata = v.mem_rdata;
      @(negedge clk);
      rv_ready = 1'b0; rv_rdata = 32'h0;
      rdy = v.is_cpu ? cpu_ready : ld_ready;
      check({t, " ready"},          {31'd0, rdy},      32'd1);
      check({t, " rv_valid drop"},  {31'd0, rv_valid}, 32'd0);
      if (v.is_cpu) check({t, " cpu_rdata"}, cpu_rdata, v.e_rdata);
    end
    ld_valid = 1'b0; cpu_valid = 1'b0;
    @(negedge clk);
    check({t, " ready pulse end"}, {30'd0, ld_ready, cpu_ready}, 32'd0);
    check({t, " idle busy"},       {31'd0, busy},                32'd0);
    check({t, " prot_viol"},       {31'd0, prot_viol},           {31'd0, v.e_viol});
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    reset = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    fw_lock = 1'b0; rv_ready = 1'b0; rv_rdata = '0;

    //          cpu  addr        wdata         strb  lk mem_rdata     dly blk e_addr       e_wdata       e_strb  e_rdata      viol
    vecs[0] = '{1'b0, 23'h000003, 32'h000000A5, 4'h0, 1'b0, 32'h0,        1, 1'b0, 23'h000003, 32'hA5A5A5A5, 4'b1000, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 23'h123456, 32'h0000003C, 4'h0, 1'b0, 32'h0,        2, 1'b0, 23'h123456, 32'h3C3C3C3C, 4'b0100, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 23'h400006, 32'h00000000, 4'h0, 1'b0, 32'hDEADBEEF, 5, 1'b0, 23'h400004, 32'h00000000, 4'b0000, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 23'h000100, 32'h00001234, 4'hF, 1'b1, 32'h0,        1, 1'b1, 23'h0,      32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[4] = '{1'b1, 23'h040000, 32'h00001234, 4'hF, 1'b1, 32'h0BADF00D, 1, 1'b0, 23'h040000, 32'h00001234, 4'b1111, 32'h0BADF00D, 1'b1};
    vecs[5] = '{1'b1, 23'h000100, 32'h00000000, 4'h0, 1'b1, 32'h000055AA, 3, 1'b0, 23'h000100, 32'h00000000, 4'b0000, 32'h000055AA, 1'b1};
    vecs[6] = '{1'b0, 23'h000101, 32'h0000007E, 4'h0, 1'b1, 32'h0,        1, 1'b0, 23'h000101, 32'h7E7E7E7E, 4'b0010, 32'h0,        1'b1};
    vecs[7] = '{1'b1, 23'h03FFFE, 32'hCAFEF00D, 4'h3, 1'b1, 32'h0,        1, 1'b1, 23'h0,      32'h0,        4'b0000, 32'h0,        1'b1};

    // Reset state
    do_reset();
    @(negedge clk);
    check_reset_values("reset");

    // Stray rv_ready in IDLE is ignored
    rv_ready = 1'b1; rv_rdata = 32'h11112222;
    @(negedge clk);
    rv_ready = 1'b0;
    @(negedge clk);
    check("stray rdy busy",   {31'd0, busy},                32'd0);
    check("stray rdy ready",  {30'd0, ld_ready, cpu_ready}, 32'd0);
    check("stray rdy rvalid", {31'd0, rv_valid},            32'd0);
    check("stray rdy rdata",  cpu_rdata,                    32'd0);

    // Table-driven single-requester transactions
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Both requesters held after reset: LD, CPU, LD, CPU
    do_reset();
    fw_lock = 1'b0;
    ld_valid = 1'b1; ld_addr = 23'h000010; ld_data = 8'h5A;
    cpu_valid = 1'b1; cpu_addr = 23'h000020; cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
    for (int g = 0; g < 4; g++) begin
      bit exp_cpu;
      exp_cpu = (g % 2) == 1;
      wait_event($sformatf("alt%0d", g), n);
      check($sformatf("alt%0d rv_valid", g), {31'd0, rv_valid}, 32'd1);
      if (g > 0) check($sformatf("alt%0d gap", g), n, 32'd2);
      check($sformatf("alt%0d rv_addr", g), {9'd0, rv_addr}, exp_cpu ? 32'h20 : 32'h10);
      rv_ready = 1'b1; rv_rdata = 32'hA0 + g;
      @(negedge clk);
      rv_ready = 1'b0;
      check($sformatf("alt%0d readies", g), {30'd0, ld_ready, cpu_ready},
            exp_cpu ? 32'd1 : 32'd2);
      check($sformatf("alt%0d rv drop", g), {31'd0, rv_valid}, 32'd0);
    end
    ld_valid = 1'b0; cpu_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Loader drops valid mid-access; completion still pulses ld_ready
    ld_valid = 1'b1; ld_addr = 23'h000041; ld_data = 8'h99;
    wait_event("drop", n);
    check("drop rv_wstrb", {28'd0, rv_wstrb}, 32'h2);
    ld_valid = 1'b0;
    @(negedge clk);
    check("drop held", {31'd0, rv_valid}, 32'd1);
    rv_ready = 1'b1;
    @(negedge clk);
    rv_ready = 1'b0;
    check("drop ld_ready", {31'd0, ld_ready}, 32'd1);
    @(negedge clk);

    // Reset during an outstanding CPU access, then a late rv_ready
    fw_lock = 1'b1;
    cpu_valid = 1'b1; cpu_addr = 23'h000200; cpu_wdata = 32'h1; cpu_wstrb = 4'h1;
    wait_event("rstmid", n);  // blocked write sets prot_viol
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid viol set", {31'd0, prot_viol}, 32'd1);
    cpu_valid = 1'b1; cpu_addr = 23'h400000; cpu_wstrb = 4'h0;
    wait_event("rstmid2", n);
    check("rstmid rv_valid", {31'd0, rv_valid}, 32'd1);
    reset = 1'b1; cpu_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid rv drop", {31'd0, rv_valid}, 32'd0);
    rv_ready = 1'b1; rv_rdata = 32'h77777777;
    @(negedge clk);
    rv_ready = 1'b0;
    @(negedge clk);
    check_reset_values("post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
